// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the core request port, the debug/loader request
// port, the core stall and the data-memory command/response lines.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system's view: the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Core (MEM stage) port
    logic              c_req;
    logic              c_we;
    logic [1:0]        c_size;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [31:0]       c_rdata;
    logic              c_err;

    // Debug / loader port
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              core_stall;

    // Memory command and registered read data
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  c_req, c_we, c_size, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output core_stall,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_size, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  core_stall,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM
// stage and the debug/loader port. It checks alignment, picks one winner per
// cycle, builds the store byte lanes, and returns zero-extended load data one
// cycle after the grant.
// Optional feature: define DMEM_ARB_RR_EN to select round-robin arbitration.
// Without it, the core has fixed priority and a starvation counter forces a
// debug grant after STARVE_MAX consecutive denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk1,
    input  logic          rst,        // asynchronous, active low
    dmem_arbiter_if.slave bus
);
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Returns 1 when the size/offset pair cannot be served in a single word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    logic              sel_dbg;    // 1 = the debug port wins this cycle
    logic              any_gnt;
    logic              w_we;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_mis;
    logic              issue;

    // Load bookkeeping for the response returned next cycle
    logic       pend_vld_q, pend_vld_d;
    logic       pend_own_q, pend_own_d;
    logic [1:0] pend_size_q, pend_size_d;
    logic [1:0] pend_off_q, pend_off_d;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;

    // On contention the port that was not granted last time wins.
    always_comb begin
        sel_dbg = 1'b0;
        if (bus.c_req && bus.d_req) begin
            sel_dbg = (last_q == PORT_CORE);
        end else begin
            sel_dbg = bus.d_req;
        end
        last_d = last_q;
        if (any_gnt) begin
            last_d = sel_dbg;
        end
    end

    // Last-grant register; it resets to debug so the core wins first.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_DBG;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    // The core has priority unless the debug port has waited STARVE_MAX cycles.
    always_comb begin
        sel_dbg  = bus.d_req && (!bus.c_req || (starve_q >= CNT_W'(STARVE_MAX)));
        starve_d = starve_q;
        if (!bus.d_req || bus.d_gnt) begin
            starve_d = '0;
        end else if (starve_q < CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Counts consecutive cycles in which debug requested and was denied.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Select the winner, check alignment and build the memory command.
    // While rst is low every combinational output is forced to 0.
    always_comb begin
        any_gnt = rst && (bus.c_req || bus.d_req);
        w_we    = sel_dbg ? bus.d_we    : bus.c_we;
        w_size  = sel_dbg ? bus.d_size  : bus.c_size;
        w_addr  = sel_dbg ? bus.d_addr  : bus.c_addr;
        w_wdata = sel_dbg ? bus.d_wdata : bus.c_wdata;
        w_mis   = misaligned(w_size, w_addr[1:0]);
        issue   = any_gnt && !w_mis;

        bus.c_gnt      = any_gnt && !sel_dbg;
        bus.d_gnt      = any_gnt && sel_dbg;
        bus.c_err      = bus.c_gnt && w_mis;
        bus.d_err      = bus.d_gnt && w_mis;
        bus.core_stall = rst && bus.c_req && !bus.c_gnt;

        bus.mem_en    = issue;
        bus.mem_we    = issue && w_we;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'h0;
        bus.mem_wdata = 32'h0;
        if (issue) begin
            bus.mem_addr = w_addr[ADDR_W-1:2];
            case (w_size)
                2'b00:   bus.mem_wdata = {4{w_wdata[7:0]}};
                2'b01:   bus.mem_wdata = {2{w_wdata[15:0]}};
                default: bus.mem_wdata = w_wdata;
            endcase
            if (w_we) begin
                case (w_size)
                    2'b00:   bus.mem_be = 4'b0001 << w_addr[1:0];
                    2'b01:   bus.mem_be = 4'b0011 << w_addr[1:0];
                    default: bus.mem_be = 4'hF;
                endcase
            end
        end

        pend_vld_d  = issue && !w_we;
        pend_own_d  = sel_dbg;
        pend_size_d = w_size;
        pend_off_d  = w_addr[1:0];
    end

    // Remember owner, size and byte offset of the load issued this cycle.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            pend_vld_q  <= 1'b0;
            pend_own_q  <= PORT_DBG;
            pend_size_q <= 2'b00;
            pend_off_q  <= 2'b00;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_own_q  <= pend_own_d;
            pend_size_q <= pend_size_d;
            pend_off_q  <= pend_off_d;
        end
    end

    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    // Align the returned word to the access offset, zero-extend it and steer it to its owner.
    always_comb begin
        rd_shift = bus.mem_rdata >> {pend_off_q, 3'b000};
        case (pend_size_q)
            2'b00:   rd_ext = {24'h0, rd_shift[7:0]};
            2'b01:   rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
        bus.c_rvalid = pend_vld_q && (pend_own_q == PORT_CORE);
        bus.d_rvalid = pend_vld_q && (pend_own_q == PORT_DBG);
        bus.c_rdata  = bus.c_rvalid ? rd_ext : 32'h0;
        bus.d_rdata  = bus.d_rvalid ? rd_ext : 32'h0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a scoreboard. The stimulus pushes
// the expected grant-cycle command and the expected load responses. A
// negedge monitor pops and compares them whenever the DUT grants or returns
// read data.
module tb_dmem_arbiter;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
        .clk1 (clk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    // Word-addressed memory with registered read and byte-enable writes
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    typedef struct {
        bit          port;   // 0 core, 1 debug
        bit          err;
        bit          en;
        bit          we;
        logic [3:0]  be;
        logic [7:0]  maddr;
        logic [31:0] wdata;
        bit          stall;
    } gexp_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int checks = 0;
    int errors = 0;

    // Monitor: compare every grant and every read response with the queues
    always @(negedge clk) begin
        if (rst) begin
            if (bus.c_gnt || bus.d_gnt) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: c_gnt=%0b d_gnt=%0b required none", bus.c_gnt, bus.d_gnt);
                end else begin
                    gexp_t g;
                    bit ok;
                    g = gq.pop_front();
                    ok = (bus.d_gnt == g.port) && (bus.c_gnt == !g.port)
                      && (bus.c_err == (g.err && !g.port)) && (bus.d_err == (g.err && g.port))
                      && (bus.mem_en == g.en) && (bus.mem_we == g.we) && (bus.mem_be == g.be)
                      && (!g.en || bus.mem_addr == g.maddr)
                      && (!(g.en && g.we) || bus.mem_wdata == g.wdata)
                      && (bus.core_stall == g.stall);
                    if (!ok) begin
                        errors++;
                        $display("FAIL grant: got cg=%0b dg=%0b ce=%0b de=%0b en=%0b we=%0b be=%h a=%h wd=%h st=%0b; required port=%0b err=%0b en=%0b we=%0b be=%h a=%h wd=%h st=%0b",
                                 bus.c_gnt, bus.d_gnt, bus.c_err, bus.d_err, bus.mem_en, bus.mem_we, bus.mem_be,
                                 bus.mem_addr, bus.mem_wdata, bus.core_stall,
                                 g.port, g.err, g.en, g.we, g.be, g.maddr, g.wdata, g.stall);
                    end
                end
            end
            if (bus.c_rvalid || bus.d_rvalid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: c_rvalid=%0b d_rvalid=%0b required none", bus.c_rvalid, bus.d_rvalid);
                end else begin
                    rexp_t r;
                    logic [31:0] got;
                    r = rq.pop_front();
                    got = r.port ? bus.d_rdata : bus.c_rdata;
                    if (bus.c_rvalid == r.port || bus.d_rvalid != r.port || got != r.data) begin
                        errors++;
                        $display("FAIL rdata: got c_rv=%0b d_rv=%0b data=%h; required port=%0b data=%h",
                                 bus.c_rvalid, bus.d_rvalid, got, r.port, r.data);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input bit req, input bit we, input logic [1:0] sz,
                            input logic [9:0] a, input logic [31:0] wd);
        bus.c_req = req; bus.c_we = we; bus.c_size = sz; bus.c_addr = a; bus.c_wdata = wd;
    endtask

    task automatic set_dbg(input bit req, input bit we, input logic [1:0] sz,
                           input logic [9:0] a, input logic [31:0] wd);
        bus.d_req = req; bus.d_we = we; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
    endtask

    task automatic exp_gnt(input bit port, input bit err, input bit we, input logic [3:0] be,
                           input logic [9:0] a, input logic [31:0] wd, input bit stall);
        gexp_t g;
        g.port = port; g.err = err; g.en = !err; g.we = we && !err; g.be = be;
        g.maddr = a[9:2]; g.wdata = wd; g.stall = stall;
        gq.push_back(g);
    endtask

    task automatic exp_rsp(input bit port, input logic [31:0] d);
        rexp_t r;
        r.port = port; r.data = d;
        rq.push_back(r);
    endtask

    // Every DUT output must read 0 while reset is held.
    task automatic check_zero(input string tag);
        logic [3:0]  hs;
        logic [45:0] cmd;
        logic [65:0] rsp;
        hs  = {bus.c_gnt, bus.d_gnt, bus.c_err | bus.d_err, bus.core_stall};
        cmd = {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
        rsp = {bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata};
        checks += 3;
        if (hs != 0)  begin errors++; $display("FAIL %s_handshake: got %b required 0", tag, hs); end
        if (cmd != 0) begin errors++; $display("FAIL %s_memcmd: got %h required 0", tag, cmd); end
        if (rsp != 0) begin errors++; $display("FAIL %s_response: got %h required 0", tag, rsp); end
    endtask

    initial begin
        set_core(1, 1, 2'b10, 10'h010, 32'h1);
        set_dbg(1, 1, 2'b10, 10'h020, 32'h2);
        #12;
        check_zero("reset");
        set_core(0, 0, 2'b00, 10'h0, 32'h0);
        set_dbg(0, 0, 2'b00, 10'h0, 32'h0);
        rst = 1'b1;

        // Core SW then LW to the same word
        next_cycle(); set_core(1, 1, 2'b10, 10'h010, 32'h12345678);
        exp_gnt(0, 0, 1, 4'hF, 10'h010, 32'h12345678, 0);
        next_cycle(); set_core(1, 0, 2'b10, 10'h010, 32'h0);
        exp_gnt(0, 0, 0, 4'h0, 10'h010, 32'h0, 0); exp_rsp(0, 32'h12345678);
        // Core SB 0xAB at 0x13, LB and LH back
        next_cycle(); set_core(1, 1, 2'b00, 10'h013, 32'h000000AB);
        exp_gnt(0, 0, 1, 4'b1000, 10'h013, 32'hABABABAB, 0);
        next_cycle(); set_core(1, 0, 2'b00, 10'h013, 32'h0);
        exp_gnt(0, 0, 0, 4'h0, 10'h013, 32'h0, 0); exp_rsp(0, 32'h000000AB);
        next_cycle(); set_core(1, 0, 2'b01, 10'h012, 32'h0);
        exp_gnt(0, 0, 0, 4'h0, 10'h012, 32'h0, 0); exp_rsp(0, 32'h0000AB34);
        // Debug SW 0, SH 0xBEEF at 0x22, LW back
        next_cycle(); set_core(0, 0, 2'b00, 10'h0, 32'h0); set_dbg(1, 1, 2'b10, 10'h020, 32'h0);
        exp_gnt(1, 0, 1, 4'hF, 10'h020, 32'h0, 0);
        next_cycle(); set_dbg(1, 1, 2'b01, 10'h022, 32'h0000BEEF);
        exp_gnt(1, 0, 1, 4'b1100, 10'h022, 32'hBEEFBEEF, 0);
        next_cycle(); set_dbg(1, 0, 2'b10, 10'h020, 32'h0);
        exp_gnt(1, 0, 0, 4'h0, 10'h020, 32'h0, 0); exp_rsp(1, 32'hBEEF0000);
        // Misaligned accesses: LH 0x05, SW 0x02, size 11
        next_cycle(); set_dbg(0, 0, 2'b00, 10'h0, 32'h0); set_core(1, 0, 2'b01, 10'h005, 32'h0);
        exp_gnt(0, 1, 0, 4'h0, 10'h005, 32'h0, 0);
        next_cycle(); set_core(1, 1, 2'b10, 10'h002, 32'hDEADBEEF);
        exp_gnt(0, 1, 0, 4'h0, 10'h002, 32'h0, 0);
        next_cycle(); set_core(1, 0, 2'b11, 10'h000, 32'h0);
        exp_gnt(0, 1, 0, 4'h0, 10'h000, 32'h0, 0);
        // Core and debug loads in flight on consecutive cycles
        next_cycle(); set_core(1, 0, 2'b10, 10'h010, 32'h0);
        exp_gnt(0, 0, 0, 4'h0, 10'h010, 32'h0, 0); exp_rsp(0, 32'hAB345678);
        next_cycle(); set_core(0, 0, 2'b00, 10'h0, 32'h0); set_dbg(1, 0, 2'b00, 10'h023, 32'h0);
        exp_gnt(1, 0, 0, 4'h0, 10'h023, 32'h0, 0); exp_rsp(1, 32'h000000BE);
        next_cycle(); set_dbg(0, 0, 2'b00, 10'h0, 32'h0);
        next_cycle();

        // Debug LW, then reset before the response edge: the response must vanish
        next_cycle(); set_dbg(1, 0, 2'b10, 10'h020, 32'h0);
        exp_gnt(1, 0, 0, 4'h0, 10'h020, 32'h0, 0);
        @(negedge clk); #2;
        rst = 1'b0;
        #1 check_zero("rst_mid");
        next_cycle(); check_zero("rst_hold");
        set_dbg(0, 0, 2'b00, 10'h0, 32'h0);
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (3) next_cycle();

        // Both ports requesting continuously
        next_cycle();
        set_core(1, 0, 2'b10, 10'h010, 32'h0);
        set_dbg(1, 0, 2'b10, 10'h020, 32'h0);
        for (int i = 0; i < 18; i++) begin
            bit dbg;
`ifdef DMEM_ARB_RR_EN
            dbg = (i % 2) == 1;
`else
            dbg = (i % 9) == 8;
`endif
            exp_gnt(dbg, 0, 0, 4'h0, dbg ? 10'h020 : 10'h010, 32'h0, dbg);
            exp_rsp(dbg, dbg ? 32'hBEEF0000 : 32'hAB345678);
            if (i != 17) next_cycle();
        end
        next_cycle();
        set_core(0, 0, 2'b00, 10'h0, 32'h0);
        set_dbg(0, 0, 2'b00, 10'h0, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk); #1;

        checks++;
        if (gq.size() != 0) begin errors++; $display("FAIL missing_grants: got %0d left required 0", gq.size()); end
        checks++;
        if (rq.size() != 0) begin errors++; $display("FAIL missing_rvalid: got %0d left required 0", rq.size()); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage (core port) and a debug/loader port (debug port). Each cycle it arbitrates, issues at most one access, and generates byte enables for SB/SH/SW stores. It also extracts and zero-extends LB/LH/LW read data and returns it one cycle later. It sits between the MEM stage, the debug loader and the data memory inside the RISC top level, and drives the core stall.

## Interface
- `ADDR_W`, default 10: byte-address width; the memory is word-addressed with `ADDR_W-2` bits.
- `STARVE_MAX`, default 8: number of consecutive denied debug cycles before the debug port is forced a grant.
- `clk1` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `c_req` in 1, `c_we` in 1, `c_size` in 2, `c_addr` in ADDR_W, `c_wdata` in 32: core request. `c_size` encodes 00 = byte, 01 = half, 10 = word, equal to funct3[1:0].
- `c_gnt` out 1, `c_rvalid` out 1, `c_rdata` out 32, `c_err` out 1: core grant, read-response valid, read data and misalignment error.
- `d_req`, `d_we`, `d_size`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: debug port, with the same widths and meanings as the core port.
- `core_stall` out 1: asserted when `c_req` is high and `c_gnt` is low.
- `mem_en` out 1, `mem_we` out 1, `mem_be` out 4, `mem_addr` out ADDR_W-2, `mem_wdata` out 32: memory command.
- `mem_rdata` in 32: registered memory read data, valid the cycle after `mem_en` is high with `mem_we` low.

## Operation
- Requests are level-held. A request is complete in the cycle its `gnt` is high; the requester may change or drop it in the next cycle.
- `gnt`, `err`, `core_stall` and the `mem_*` command outputs are combinational from the requests and registered state. `rvalid` and `rdata` are registered.
- Alignment check runs before arbitration:
  - A half access with `addr[0]` set is misaligned.
  - A word access with `addr[1:0]` not equal to 0 is misaligned.
  - Size 11 is misaligned.
  - A misaligned winner gets `gnt` and `err` high in the same cycle and issues no memory access (`mem_en` stays 0).
- Fixed-priority arbitration (the default):
  - The core wins whenever `c_req` is high.
  - The starvation counter increments on every cycle where `d_req` is high and the debug port is not granted.
  - When the counter reaches `STARVE_MAX`, the debug port wins that cycle and the counter clears. The counter also clears on any debug grant and whenever `d_req` is low.
- Store lanes:
  - Byte store: `mem_wdata` = `{4{wdata[7:0]}}`, `mem_be` = `4'b0001 << addr[1:0]`.
  - Half store: `mem_wdata` = `{2{wdata[15:0]}}`, `mem_be` = `4'b0011 << addr[1:0]`.
  - Word store: `mem_be` = `4'hF`.
- Loads drive `mem_be` = `4'h0`.
- Every access drives `mem_addr` = `addr[ADDR_W-1:2]`.
- For each issued load, the block registers the owner, the size and `addr[1:0]`. On the next cycle:
  - The owner's `rdata` = `mem_rdata` shifted right by 8×`addr[1:0]`, then masked to the access size (zero-extended).
  - The owner's `rvalid` is high for one cycle.
  - Sign extension is the requester's job.
- Stores produce no `rvalid`.
- Back-to-back: a new grant may issue in the same cycle as the previous load's `rvalid`. Both ports may have responses in flight on consecutive cycles.

## Timing
- Reset state (asynchronous, `rst` low):
  - All outputs are 0.
  - Starvation counter = 0.
  - The pending-response register is cleared.
  - Last-grant register = debug.
- Grant latency is 0 cycles. Load data latency is 1 cycle (`rvalid` in grant cycle + 1). A store is committed at the edge ending the grant cycle.
- Reset asserted while a load is outstanding: the response is dropped and no `rvalid` appears after reset is released.
- A store followed by a load to the same word on the next grant returns the new data.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin replaces fixed priority.
  - When both ports request, the port not recorded in the last-grant register wins.
  - The last-grant register updates on every grant.
  - The starvation counter is not built and `STARVE_MAX` is ignored.
- `DMEM_ARB_RR_EN` undefined: fixed core priority with the starvation guard described under Operation.

## Test plan
- Core SW of 0x12345678 to address 0x10, then LW from 0x10: `mem_be` = F, and on the cycle after the load grant `c_rvalid` = 1 with `c_rdata` = 0x12345678.
- Core SB of 0xAB to 0x13, then LB from 0x13: `mem_be` = 4'b1000, `mem_wdata` = 0xABABABAB, and the load returns `c_rdata` = 0x000000AB.
- Fixed priority with `c_req` and `d_req` held high continuously:
  - The core is granted 8 cycles.
  - Cycle 9 grants debug with `core_stall` = 1.
  - The 8-core / 1-debug pattern then repeats.
- With `DMEM_ARB_RR_EN` and both ports requesting from reset: grants go core, debug, core, debug, and `core_stall` is high on every debug cycle.
- Core LH at 0x05: `c_gnt` = 1, `c_err` = 1, `mem_en` = 0, and no `c_rvalid` follows.
- Debug LW issued, then `rst` pulled low before the next edge: every output reads 0 and `d_rvalid` never asserts after reset is released.
